sram_ctrl: RTL
==============

Name: sram_ctrl

Overview:
Synchronous controller that converts single-word read/write requests from a clocked core into the asynchronous _OE/_WE/A/D pin protocol of the team's byte-wide SRAM model (AS6C1008-class, 55 ns access). It sits directly upstream of the ram block and owns its address, strobes and bidirectional data bus. A multi-cycle state machine enforces access time, write pulse width and bus turnaround.

Parameters:
AWIDTH, 16, address width; drives A.
DWIDTH, 8, data width; drives D.
RD_WAIT, 6, cycles _OE held low before sampling D (>=1; 6 x 10 ns covers tAA=55 ns).
WR_SETUP, 1, cycles A/D stable before _WE falls (>=1).
WR_WAIT, 5, cycles _WE held low (>=1).
TURN_CYC, 2, idle cycles after _OE rises before the next access may start (>=0; covers tOHZ=20 ns).

Ports:
clk  input  1  clock, all state changes on rising edge
_reset  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  controller idle, request accepted on req_valid && req_ready at rising clk
req_write  input  1  1=write, 0=read
req_addr  input  AWIDTH  word address
req_wdata  input  DWIDTH  write data
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  DWIDTH  read data, valid when rsp_valid after a read; held until next read completes
_OE  output  1  SRAM output enable, active low
_WE  output  1  SRAM write enable, active low
A  output  AWIDTH  SRAM address
D  inout  DWIDTH  SRAM data bus; driven only during write states, else all z

Behaviour:
- Reset (clk edge with _reset=0): state IDLE, _OE=1, _WE=1, A=0, D=z, rsp_valid=0, rsp_rdata=0, counters 0. req_ready=1 from the first edge with _reset=1 (it is low while _reset=0).
- States: IDLE, RD_ACC, TURN, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: req_ready=1. On accept at edge k: latch addr/wdata/write; A=req_addr at edge k. Read -> RD_ACC with _OE=0 from edge k. Write -> WR_SETUP with D driven = req_wdata from edge k, _WE stays 1.
- RD_ACC: _OE=0 for exactly RD_WAIT cycles. At edge k+RD_WAIT: rsp_rdata<=D (sampled, x/z passed through unchanged), _OE<=1, rsp_valid<=1 for one cycle, next TURN (or IDLE if TURN_CYC=0).
- TURN: _OE=1, _WE=1, D=z, req_ready=0 for TURN_CYC cycles, then IDLE. Read request-to-next-accept minimum = RD_WAIT+TURN_CYC+1 edges.
- WR_SETUP: WR_SETUP cycles, then _WE<=0 -> WR_PULSE.
- WR_PULSE: _WE=0 for WR_WAIT cycles, A and D held constant; then _WE<=1 -> WR_HOLD.
- WR_HOLD: one cycle, _WE=1, A and D still driven; next edge: D<=z, rsp_valid<=1 for one cycle, -> IDLE. rsp_rdata unchanged by writes.
- Invariants: _OE and _WE never both 0; D never driven while _OE=0; A changes only on accept or reset; req_ready=0 outside IDLE; requests presented while busy are ignored (not queued) and must be held by requester.
- Back-to-back: rsp_valid and req_ready may be high in the same cycle (write complete, or read with TURN_CYC=0); a new accept then is legal.
- Reset mid-operation: next edge forces reset values immediately; aborted access produces no rsp_valid; an aborted write may leave the addressed word corrupted (accepted, not detected).
- Address wrap: none; A is a plain latch, 0 and 2^AWIDTH-1 handled identically.
- Counter width $clog2 of max(RD_WAIT,WR_SETUP,WR_WAIT,TURN_CYC)+1; illegal parameter values (<1 where stated) trigger $error at elaboration.

Test Plan:
- Reset: hold _reset=0 for 3 cycles with req_valid=1 -> _OE=1, _WE=1, A=0, D=z, req_ready=0, rsp_valid=0; release -> req_ready=1 next cycle, no access started until the following edge.
- Write 0xA5 to 0x1234 then read 0x1234, with defaults, clk 10 ns -> _WE low exactly 50 ns, rsp_valid after read at accept+6 edges, rsp_rdata=0xA5.
- Boundaries: write 0x3C to 0x0000 and 0xC3 to 0xFFFF, read both -> 0x3C, 0xC3; no aliasing.
- Write immediately followed by read (req_valid held high) -> bus monitor: no cycle with D driven while _OE=0, no cycle with _OE=_WE=0; read data equals written value.
- Hold req_valid high with changing req_addr during RD_ACC -> A unchanged, only one access performed, req_ready=0 until TURN completes (9 edges after accept with defaults).
- Assert _reset=0 during WR_PULSE -> next edge _WE=1, D=z, no rsp_valid; subsequent read of another address unaffected.

Source files
------------

// File: rtl/sram_ctrl.sv
// Synchronous-to-asynchronous SRAM pin controller: turns single-word core requests
// into _OE/_WE/A/D sequences with programmable access, write-pulse and turnaround timing.
module sram_ctrl #(
  parameter int unsigned AWIDTH   = 16,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned RD_WAIT  = 6,
  parameter int unsigned WR_SETUP = 1,
  parameter int unsigned WR_WAIT  = 5,
  parameter int unsigned TURN_CYC = 2
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              _OE,
  output logic              _WE,
  output logic [AWIDTH-1:0] A,
  inout  wire  [DWIDTH-1:0] D
);

  localparam int unsigned MAX_AB  = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
  localparam int unsigned MAX_CD  = (WR_WAIT > TURN_CYC) ? WR_WAIT : TURN_CYC;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  // Counters load "cycles - 1" and the state advances when they reach zero.
  localparam logic [CW-1:0] RD_LOAD = CW'((RD_WAIT  > 0) ? RD_WAIT  - 1 : 0);
  localparam logic [CW-1:0] SU_LOAD = CW'((WR_SETUP > 0) ? WR_SETUP - 1 : 0);
  localparam logic [CW-1:0] WW_LOAD = CW'((WR_WAIT  > 0) ? WR_WAIT  - 1 : 0);
  localparam logic [CW-1:0] TN_LOAD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  if (RD_WAIT < 1) begin : g_bad_rd_wait
    $error("sram_ctrl: RD_WAIT must be >= 1");
  end
  if (WR_SETUP < 1) begin : g_bad_wr_setup
    $error("sram_ctrl: WR_SETUP must be >= 1");
  end
  if (WR_WAIT < 1) begin : g_bad_wr_wait
    $error("sram_ctrl: WR_WAIT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ACC,
    S_TURN,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  state_t            r_state,   w_state;
  logic [CW-1:0]     r_cnt,     w_cnt;
  logic [AWIDTH-1:0] r_addr,    w_addr;
  logic [DWIDTH-1:0] r_wdata,   w_wdata;
  logic [DWIDTH-1:0] r_rdata,   w_rdata;
  logic              r_d_oe,    w_d_oe;
  logic              r_oe_n,    w_oe_n;
  logic              r_we_n,    w_we_n;
  logic              r_rsp,     w_rsp;
  logic              r_ready,   w_ready;
  logic              w_accept;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_d_oe  <= 1'b0;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_rsp   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
      r_d_oe  <= w_d_oe;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_rsp   <= w_rsp;
      r_ready <= w_ready;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rdata  = r_rdata;
    w_d_oe   = r_d_oe;
    w_oe_n   = r_oe_n;
    w_we_n   = r_we_n;
    w_rsp    = 1'b0;
    w_accept = req_valid && r_ready;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr  = req_addr;
          w_wdata = req_wdata;
          if (req_write) begin
            w_state = S_WR_SETUP;
            w_d_oe  = 1'b1;
            w_cnt   = SU_LOAD;
          end else begin
            w_state = S_RD_ACC;
            w_oe_n  = 1'b0;
            w_cnt   = RD_LOAD;
          end
        end
      end
      S_RD_ACC: begin
        if (r_cnt == '0) begin
          w_rdata = D;
          w_oe_n  = 1'b1;
          w_rsp   = 1'b1;
          if (TURN_CYC > 0) begin
            w_state = S_TURN;
            w_cnt   = TN_LOAD;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_TURN: begin
        if (r_cnt == '0) begin
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_WR_SETUP: begin
        if (r_cnt == '0) begin
          w_we_n  = 1'b0;
          w_state = S_WR_PULSE;
          w_cnt   = WW_LOAD;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_WR_PULSE: begin
        if (r_cnt == '0) begin
          w_we_n  = 1'b1;
          w_state = S_WR_HOLD;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_WR_HOLD: begin
        w_d_oe  = 1'b0;
        w_rsp   = 1'b1;
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Ready is registered: high in exactly the cycles the FSM sits in IDLE.
    w_ready = (w_state == S_IDLE);
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;
  assign _OE       = r_oe_n;
  assign _WE       = r_we_n;
  assign A         = r_addr;
  assign D         = r_d_oe ? r_wdata : {DWIDTH{1'bz}};

endmodule
